// File: rtl/mem_req_arbiter_if.sv
// SRAM-style request/response bus used on both sides of mem_req_arbiter.
//   req/wr/size/wstrb/addr/wdata : request fields, driven by the requester
//   addr_ok                      : request accepted this cycle
//   data_ok/rdata                : response valid / response data
// Modports:
//   master : the requesting side (drives request fields)
//   slave  : the responding side (drives addr_ok, data_ok, rdata)
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Two-master to one-slave SRAM-style request arbiter.
// The data and instruction masters share one slave port. Requests are granted
// combinationally in IDLE (data wins under contention, except that inst is
// taken right after a data acceptance that happened while inst was waiting).
// A granted request that is not yet accepted is held until the slave takes it.
// Each accepted transfer pushes a source tag into an in-order FIFO; slave
// responses pop the head tag and are routed to the owning master.
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous, active-high reset
//   inst_sram  : instruction master bus (arbiter is the responder)
//   data_sram  : data master bus (arbiter is the responder)
//   mem        : shared slave bus (arbiter is the requester)
// Parameter:
//   OUTSTANDING : max accepted-but-unanswered transfers (power of two, 2..8)
module mem_req_arbiter #(
    parameter int unsigned OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.slave  inst_sram,
    mem_req_arbiter_if.slave  data_sram,
    mem_req_arbiter_if.master mem
);

    localparam int unsigned PW = $clog2(OUTSTANDING);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_D = 2'd1,
        HOLD_I = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_last_contend;  // last accept was data while inst was requesting
    logic [OUTSTANDING-1:0] r_tags;          // 1 = data, 0 = inst
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_block;
    logic w_head;
    logic w_grant_valid;
    logic w_grant_data;
    logic w_mem_req;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(OUTSTANDING));
    assign w_head  = r_tags[r_rptr];
    // Responses with nothing outstanding are dropped (covers pre-reset transfers).
    assign w_pop   = mem.data_ok && !w_empty && !reset;
    // A same-cycle pop frees a slot, so a full FIFO only blocks without one.
    assign w_block = w_full && !w_pop;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_valid = 1'b0;
        w_grant_data  = 1'b0;
        w_mem_req     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_block) begin
                    if (data_sram.req && inst_sram.req) begin
                        w_grant_valid = 1'b1;
                        w_grant_data  = !r_last_contend;
                    end else if (data_sram.req) begin
                        w_grant_valid = 1'b1;
                        w_grant_data  = 1'b1;
                    end else if (inst_sram.req) begin
                        w_grant_valid = 1'b1;
                        w_grant_data  = 1'b0;
                    end
                end
                w_mem_req = w_grant_valid;
                if (w_grant_valid && !mem.addr_ok) begin
                    w_state_nxt = w_grant_data ? HOLD_D : HOLD_I;
                end
            end
            HOLD_D: begin
                w_grant_valid = 1'b1;
                w_grant_data  = 1'b1;
                w_mem_req     = data_sram.req;
                if (w_mem_req && mem.addr_ok) begin
                    w_state_nxt = IDLE;
                end
            end
            HOLD_I: begin
                w_grant_valid = 1'b1;
                w_grant_data  = 1'b0;
                w_mem_req     = inst_sram.req;
                if (w_mem_req && mem.addr_ok) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (reset) begin
            w_mem_req = 1'b0;
        end
    end

    assign w_push = w_mem_req && mem.addr_ok;

    // Slave request fields follow the granted (or held) master.
    assign mem.req   = w_mem_req;
    assign mem.wr    = w_grant_data ? data_sram.wr    : inst_sram.wr;
    assign mem.size  = w_grant_data ? data_sram.size  : inst_sram.size;
    assign mem.wstrb = w_grant_data ? data_sram.wstrb : inst_sram.wstrb;
    assign mem.addr  = w_grant_data ? data_sram.addr  : inst_sram.addr;
    assign mem.wdata = w_grant_data ? data_sram.wdata : inst_sram.wdata;

    assign inst_sram.addr_ok = w_push && !w_grant_data;
    assign data_sram.addr_ok = w_push &&  w_grant_data;
    assign inst_sram.data_ok = w_pop  && !w_head;
    assign data_sram.data_ok = w_pop  &&  w_head;
    assign inst_sram.rdata   = mem.rdata;
    assign data_sram.rdata   = mem.rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_last_contend <= 1'b0;
            r_tags         <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_count        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_tags[r_wptr] <= w_grant_data;
                r_wptr         <= r_wptr + 1'b1;
                r_last_contend <= w_grant_data && inst_sram.req;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter (OUTSTANDING = 4).
// Inputs are driven just after the falling edge; outputs are checked 1 time
// unit later, well away from the rising edge. Expected response routing
// comes from a queue of tags pushed whenever the bench drives a cycle in
// which it expects an acceptance.
module tb_mem_req_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   exp_q[$];

    mem_req_arbiter_if inst_if ();
    mem_req_arbiter_if data_if ();
    mem_req_arbiter_if mem_if ();

    mem_req_arbiter #(.OUTSTANDING(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .inst_sram (inst_if),
        .data_sram (data_if),
        .mem       (mem_if)
    );

    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL timeout reached got=running exp=finished");
        $fatal(1);
    end

    task automatic clear_inputs();
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.wstrb = 4'h0;
        inst_if.addr = '0; inst_if.wdata = '0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.wstrb = 4'h0;
        data_if.addr = '0; data_if.wdata = '0;
        mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1;
        inst_if.req = 1; data_if.req = 1;
        mem_if.addr_ok = 1; mem_if.data_ok = 1; mem_if.rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (mem_if.req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_if.req); end
        total++; if (inst_if.addr_ok !== 1'b0) begin bad++; $display("FAIL reset_inst_addr_ok got=%0b exp=0", inst_if.addr_ok); end
        total++; if (data_if.addr_ok !== 1'b0) begin bad++; $display("FAIL reset_data_addr_ok got=%0b exp=0", data_if.addr_ok); end
        total++; if (inst_if.data_ok !== 1'b0) begin bad++; $display("FAIL reset_inst_data_ok got=%0b exp=0", inst_if.data_ok); end
        total++; if (data_if.data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_data_ok got=%0b exp=0", data_if.data_ok); end
        @(negedge clk);
        clear_inputs();
        reset = 0;
        exp_q.delete();
    endtask

    task automatic test_alternation();
        do_reset();
        @(negedge clk);
        data_if.req = 1; data_if.addr = 32'h0000_1004;
        inst_if.req = 1; inst_if.addr = 32'h1C00_0000;
        mem_if.addr_ok = 1;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL alt_c0_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        total++; if (inst_if.addr_ok !== 1'b0) begin bad++; $display("FAIL alt_c0_inst_addr_ok got=%0b exp=0", inst_if.addr_ok); end
        total++; if (mem_if.addr !== 32'h0000_1004) begin bad++; $display("FAIL alt_c0_addr got=%h exp=00001004", mem_if.addr); end
        exp_q.push_back(1'b1);
        @(negedge clk);
        data_if.addr = 32'h0000_1008;
        #1;
        total++; if (inst_if.addr_ok !== 1'b1) begin bad++; $display("FAIL alt_c1_inst_addr_ok got=%0b exp=1", inst_if.addr_ok); end
        total++; if (data_if.addr_ok !== 1'b0) begin bad++; $display("FAIL alt_c1_data_addr_ok got=%0b exp=0", data_if.addr_ok); end
        total++; if (mem_if.addr !== 32'h1C00_0000) begin bad++; $display("FAIL alt_c1_addr got=%h exp=1c000000", mem_if.addr); end
        exp_q.push_back(1'b0);
        @(negedge clk);
        inst_if.addr = 32'h1C00_0004;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL alt_c2_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        total++; if (mem_if.addr !== 32'h0000_1008) begin bad++; $display("FAIL alt_c2_addr got=%h exp=00001008", mem_if.addr); end
        exp_q.push_back(1'b1);
        do_reset();
    endtask

    task automatic test_hold();
        do_reset();
        @(negedge clk);
        data_if.req = 1; data_if.addr = 32'h0000_1004; mem_if.addr_ok = 0;
        #1;
        total++; if (mem_if.req !== 1'b1) begin bad++; $display("FAIL hold_c0_mem_req got=%0b exp=1", mem_if.req); end
        total++; if (mem_if.addr !== 32'h0000_1004) begin bad++; $display("FAIL hold_c0_addr got=%h exp=00001004", mem_if.addr); end
        total++; if (data_if.addr_ok !== 1'b0) begin bad++; $display("FAIL hold_c0_data_addr_ok got=%0b exp=0", data_if.addr_ok); end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            inst_if.req = 1; inst_if.addr = 32'h1C00_0000;
            #1;
            total++; if (mem_if.addr !== 32'h0000_1004) begin bad++; $display("FAIL hold_c%0d_addr got=%h exp=00001004", i, mem_if.addr); end
            total++; if (inst_if.addr_ok !== 1'b0) begin bad++; $display("FAIL hold_c%0d_inst_addr_ok got=%0b exp=0", i, inst_if.addr_ok); end
        end
        @(negedge clk);
        mem_if.addr_ok = 1;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL hold_c3_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        total++; if (inst_if.addr_ok !== 1'b0) begin bad++; $display("FAIL hold_c3_inst_addr_ok got=%0b exp=0", inst_if.addr_ok); end
        total++; if (mem_if.addr !== 32'h0000_1004) begin bad++; $display("FAIL hold_c3_addr got=%h exp=00001004", mem_if.addr); end
        @(negedge clk);
        data_if.req = 0;
        #1;
        total++; if (inst_if.addr_ok !== 1'b1) begin bad++; $display("FAIL hold_c4_inst_addr_ok got=%0b exp=1", inst_if.addr_ok); end
        total++; if (mem_if.addr !== 32'h1C00_0000) begin bad++; $display("FAIL hold_c4_addr got=%h exp=1c000000", mem_if.addr); end
        do_reset();
    endtask

    task automatic test_full();
        bit e;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            inst_if.req = 1; inst_if.addr = 32'h1C00_0000 + 32'(4 * k); mem_if.addr_ok = 1;
            #1;
            total++; if (inst_if.addr_ok !== 1'b1) begin bad++; $display("FAIL full_fill%0d_inst_addr_ok got=%0b exp=1", k, inst_if.addr_ok); end
            exp_q.push_back(1'b0);
        end
        @(negedge clk);
        inst_if.addr = 32'h1C00_0010;
        #1;
        total++; if (mem_if.req !== 1'b0) begin bad++; $display("FAIL full_block_mem_req got=%0b exp=0", mem_if.req); end
        total++; if (inst_if.addr_ok !== 1'b0) begin bad++; $display("FAIL full_block_inst_addr_ok got=%0b exp=0", inst_if.addr_ok); end
        @(negedge clk);
        mem_if.addr_ok = 0; mem_if.data_ok = 1; mem_if.rdata = 32'h0000_00A0;
        #1;
        e = exp_q.pop_front();
        total++; if (inst_if.data_ok !== !e) begin bad++; $display("FAIL full_pop_inst_data_ok got=%0b exp=%0b", inst_if.data_ok, !e); end
        total++; if (data_if.data_ok !== e) begin bad++; $display("FAIL full_pop_data_data_ok got=%0b exp=%0b", data_if.data_ok, e); end
        total++; if (inst_if.rdata !== 32'h0000_00A0) begin bad++; $display("FAIL full_pop_rdata got=%h exp=000000a0", inst_if.rdata); end
        @(negedge clk);
        mem_if.data_ok = 0;
        #1;
        total++; if (mem_if.req !== 1'b1) begin bad++; $display("FAIL full_after_pop_mem_req got=%0b exp=1", mem_if.req); end
        total++; if (mem_if.addr !== 32'h1C00_0010) begin bad++; $display("FAIL full_after_pop_addr got=%h exp=1c000010", mem_if.addr); end
        @(negedge clk);
        mem_if.addr_ok = 1;
        #1;
        total++; if (inst_if.addr_ok !== 1'b1) begin bad++; $display("FAIL full_refill_inst_addr_ok got=%0b exp=1", inst_if.addr_ok); end
        exp_q.push_back(1'b0);
        @(negedge clk);
        inst_if.req = 0; mem_if.addr_ok = 0;
    endtask

    // Continues from the full FIFO left by test_full.
    task automatic test_push_pop_full();
        bit e;
        @(negedge clk);
        data_if.req = 1; data_if.addr = 32'h0000_2000; mem_if.addr_ok = 1;
        mem_if.data_ok = 1; mem_if.rdata = 32'h0000_00B1;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL pp_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        e = exp_q.pop_front();
        total++; if (inst_if.data_ok !== !e) begin bad++; $display("FAIL pp_inst_data_ok got=%0b exp=%0b", inst_if.data_ok, !e); end
        total++; if (data_if.data_ok !== e) begin bad++; $display("FAIL pp_data_data_ok got=%0b exp=%0b", data_if.data_ok, e); end
        exp_q.push_back(1'b1);
        @(negedge clk);
        mem_if.data_ok = 0;
        #1;
        total++; if (mem_if.req !== 1'b0) begin bad++; $display("FAIL pp_still_full_mem_req got=%0b exp=0", mem_if.req); end
        total++; if (data_if.addr_ok !== 1'b0) begin bad++; $display("FAIL pp_still_full_addr_ok got=%0b exp=0", data_if.addr_ok); end
        @(negedge clk);
        data_if.req = 0; mem_if.addr_ok = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_if.data_ok = 1; mem_if.rdata = 32'h0000_00C0 + 32'(i);
            #1;
            e = exp_q.pop_front();
            total++; if (data_if.data_ok !== e) begin bad++; $display("FAIL pp_drain%0d_data_data_ok got=%0b exp=%0b", i, data_if.data_ok, e); end
            total++; if (inst_if.data_ok !== !e) begin bad++; $display("FAIL pp_drain%0d_inst_data_ok got=%0b exp=%0b", i, inst_if.data_ok, !e); end
            total++; if (data_if.rdata !== 32'h0000_00C0 + 32'(i)) begin bad++; $display("FAIL pp_drain%0d_rdata got=%h exp=%h", i, data_if.rdata, 32'h0000_00C0 + 32'(i)); end
        end
        @(negedge clk);
        mem_if.data_ok = 0;
    endtask

    task automatic test_in_order();
        bit e;
        logic [31:0] rd;
        do_reset();
        @(negedge clk);
        data_if.req = 1; data_if.addr = 32'h0000_3000; mem_if.addr_ok = 1;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL ord_acc0_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        exp_q.push_back(1'b1);
        @(negedge clk);
        data_if.req = 0; inst_if.req = 1; inst_if.addr = 32'h1C00_0100;
        #1;
        total++; if (inst_if.addr_ok !== 1'b1) begin bad++; $display("FAIL ord_acc1_inst_addr_ok got=%0b exp=1", inst_if.addr_ok); end
        exp_q.push_back(1'b0);
        @(negedge clk);
        inst_if.req = 0; data_if.req = 1; data_if.addr = 32'h0000_3004;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL ord_acc2_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        exp_q.push_back(1'b1);
        @(negedge clk);
        data_if.req = 0; mem_if.addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rd = 32'h11 * 32'(i + 1);
            mem_if.data_ok = 1; mem_if.rdata = rd;
            #1;
            e = exp_q.pop_front();
            total++; if (data_if.data_ok !== e) begin bad++; $display("FAIL ord_rsp%0d_data_data_ok got=%0b exp=%0b", i, data_if.data_ok, e); end
            total++; if (inst_if.data_ok !== !e) begin bad++; $display("FAIL ord_rsp%0d_inst_data_ok got=%0b exp=%0b", i, inst_if.data_ok, !e); end
            total++; if ((e ? data_if.rdata : inst_if.rdata) !== rd) begin bad++; $display("FAIL ord_rsp%0d_rdata got=%h exp=%h", i, (e ? data_if.rdata : inst_if.rdata), rd); end
        end
        @(negedge clk);
        mem_if.data_ok = 1; mem_if.rdata = 32'h44;
        #1;
        total++; if (data_if.data_ok !== 1'b0) begin bad++; $display("FAIL ord_empty_data_data_ok got=%0b exp=0", data_if.data_ok); end
        total++; if (inst_if.data_ok !== 1'b0) begin bad++; $display("FAIL ord_empty_inst_data_ok got=%0b exp=0", inst_if.data_ok); end
        @(negedge clk);
        mem_if.data_ok = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        data_if.req = 1; data_if.addr = 32'h0000_4000; mem_if.addr_ok = 1;
        #1;
        total++; if (data_if.addr_ok !== 1'b1) begin bad++; $display("FAIL rmid_acc0_data_addr_ok got=%0b exp=1", data_if.addr_ok); end
        @(negedge clk);
        data_if.req = 0; inst_if.req = 1; inst_if.addr = 32'h1C00_0200;
        #1;
        total++; if (inst_if.addr_ok !== 1'b1) begin bad++; $display("FAIL rmid_acc1_inst_addr_ok got=%0b exp=1", inst_if.addr_ok); end
        @(negedge clk);
        clear_inputs();
        reset = 1;
        @(negedge clk);
        reset = 0;
        exp_q.delete();
        mem_if.data_ok = 1; mem_if.rdata = 32'h55;
        #1;
        total++; if (data_if.data_ok !== 1'b0) begin bad++; $display("FAIL rmid_data_data_ok got=%0b exp=0", data_if.data_ok); end
        total++; if (inst_if.data_ok !== 1'b0) begin bad++; $display("FAIL rmid_inst_data_ok got=%0b exp=0", inst_if.data_ok); end
        @(negedge clk);
        mem_if.data_ok = 0;
        #1;
        total++; if (inst_if.data_ok !== 1'b0) begin bad++; $display("FAIL rmid_after_inst_data_ok got=%0b exp=0", inst_if.data_ok); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_alternation();
        test_hold();
        test_full();
        test_push_pop_full();
        test_in_order();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
